// File: rtl/issue_queue_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Package : issue_queue_pkg
// Brief   : Shared widths and ALU control encodings for the issue queue slice.
// Rev     : 1.0
//------------------------------------------------------------------------------
package issue_queue_pkg;

  localparam int TAG_W_DEFAULT = 6;
  localparam int AGE_W_DEFAULT = 32;
  localparam int ALU_W         = 6;

  typedef enum logic [ALU_W-1:0] {
    ALU_SLL = 6'h00,
    ALU_SRL = 6'h02,
    ALU_ADD = 6'h20,
    ALU_SUB = 6'h22,
    ALU_AND = 6'h24,
    ALU_OR  = 6'h25
  } alu_ctrl_e;

endpackage
`default_nettype wire

// File: rtl/oldest_ready_select.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : oldest_ready_select
// Brief  : Combinational min-age selector over DEPTH candidates; ties -> low idx.
// Rev    : 1.0
//------------------------------------------------------------------------------
module oldest_ready_select
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AGE_W = AGE_W_DEFAULT
) (
  input  logic [DEPTH-1:0]            candidate,
  input  logic [DEPTH-1:0][AGE_W-1:0] ages,
  output logic [$clog2(DEPTH)-1:0]    grant_idx,
  output logic                        grant_valid
);

  logic [AGE_W-1:0] w_best_age;

  // Strict less-than while scanning upward keeps the lowest index on equal ages.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    w_best_age  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (candidate[i] && (!grant_valid || (ages[i] < w_best_age))) begin
        grant_idx   = ($clog2(DEPTH))'(i);
        grant_valid = 1'b1;
        w_best_age  = ages[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : issue_queue
// Brief  : Reservation station ahead of EXE; wakes on result broadcast, issues oldest ready.
// Rev    : 1.0
//------------------------------------------------------------------------------
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = TAG_W_DEFAULT,
  parameter int AGE_W = AGE_W_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   Dispatch_Valid_IN,
  output logic                   Dispatch_Ready_OUT,
  input  logic [31:0]            Instr_IN,
  input  logic [31:0]            Instr_PC_IN,
  input  logic [31:0]            OperandA_IN,
  input  logic [31:0]            OperandB_IN,
  input  logic                   OperandA_Ready_IN,
  input  logic                   OperandB_Ready_IN,
  input  logic [TAG_W-1:0]       OperandA_Tag_IN,
  input  logic [TAG_W-1:0]       OperandB_Tag_IN,
  input  logic [4:0]             WriteRegister_IN,
  input  logic                   RegWrite_IN,
  input  logic                   MemRead_IN,
  input  logic                   MemWrite_IN,
  input  logic [ALU_W-1:0]       ALU_Control_IN,
  input  logic [4:0]             ShiftAmount_IN,
  input  logic [AGE_W-1:0]       InstrAge_IN,
  input  logic                   Bcast_Valid_IN,
  input  logic [TAG_W-1:0]       Bcast_Tag_IN,
  input  logic [31:0]            Bcast_Data_IN,
  input  logic                   Flush_IN,
  input  logic                   IF_stall_request,
  output logic                   Issue_Valid_OUT,
  output logic [31:0]            Instr1_OUT,
  output logic [31:0]            Instr1_PC_OUT,
  output logic [31:0]            OperandA1_OUT,
  output logic [31:0]            OperandB1_OUT,
  output logic [4:0]             WriteRegister1_OUT,
  output logic                   RegWrite1_OUT,
  output logic [ALU_W-1:0]       ALU_Control1_OUT,
  output logic                   MemRead1_OUT,
  output logic                   MemWrite1_OUT,
  output logic [4:0]             ShiftAmount1_OUT,
  output logic [AGE_W-1:0]       InstrAge_OUT,
  output logic [$clog2(DEPTH):0] Count_OUT
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] c_FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0]            r_valid, r_a_rdy, r_b_rdy;
  logic [TAG_W-1:0]            r_a_tag [DEPTH];
  logic [TAG_W-1:0]            r_b_tag [DEPTH];
  logic [31:0]                 r_a_val [DEPTH];
  logic [31:0]                 r_b_val [DEPTH];
  logic [31:0]                 r_instr [DEPTH];
  logic [31:0]                 r_pc    [DEPTH];
  logic [4:0]                  r_wreg  [DEPTH];
  logic [4:0]                  r_shamt [DEPTH];
  logic [ALU_W-1:0]            r_alu   [DEPTH];
  logic [DEPTH-1:0]            r_regwrite, r_memread, r_memwrite;
  logic [DEPTH-1:0][AGE_W-1:0] r_age;

  logic [IDX_W-1:0] w_free_idx, w_grant_idx;
  logic             w_free_found, w_grant_valid;
  logic             w_dispatch, w_issue, w_byp_a, w_byp_b;
  logic [DEPTH-1:0] w_cand, w_alloc, w_release, w_wake_a, w_wake_b;

  assign Dispatch_Ready_OUT = (Count_OUT < c_FULL_CNT);
  assign w_dispatch = Dispatch_Valid_IN & Dispatch_Ready_OUT & ~Flush_IN & w_free_found;
  assign w_issue    = w_grant_valid & ~IF_stall_request & ~Flush_IN;
  assign w_cand     = r_valid & r_a_rdy & r_b_rdy;

  // Result arriving in the same cycle as dispatch is captured directly.
  assign w_byp_a = Bcast_Valid_IN & ~OperandA_Ready_IN & (OperandA_Tag_IN == Bcast_Tag_IN);
  assign w_byp_b = Bcast_Valid_IN & ~OperandB_Ready_IN & (OperandB_Tag_IN == Bcast_Tag_IN);

  always_comb begin
    w_free_idx   = '0;
    w_free_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_alloc   = '0;
    w_release = '0;
    w_wake_a  = '0;
    w_wake_b  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_alloc[i]   = w_dispatch & (w_free_idx == IDX_W'(i));
      w_release[i] = w_issue & (w_grant_idx == IDX_W'(i));
      w_wake_a[i]  = Bcast_Valid_IN & r_valid[i] & ~r_a_rdy[i] & (r_a_tag[i] == Bcast_Tag_IN);
      w_wake_b[i]  = Bcast_Valid_IN & r_valid[i] & ~r_b_rdy[i] & (r_b_tag[i] == Bcast_Tag_IN);
    end
  end

  oldest_ready_select #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_select (
    .candidate   (w_cand),
    .ages        (r_age),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_a_rdy <= '0;
      r_b_rdy <= '0;
    end else if (Flush_IN) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc[i]) begin
          r_valid[i] <= 1'b1;
          r_a_rdy[i] <= OperandA_Ready_IN | w_byp_a;
          r_b_rdy[i] <= OperandB_Ready_IN | w_byp_b;
        end else begin
          if (w_release[i]) r_valid[i] <= 1'b0;
          if (w_wake_a[i])  r_a_rdy[i] <= 1'b1;
          if (w_wake_b[i])  r_b_rdy[i] <= 1'b1;
        end
      end
    end
  end

  // Payload is qualified by r_valid everywhere it is read, so it needs no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alloc[i]) begin
        r_a_tag[i]    <= OperandA_Tag_IN;
        r_b_tag[i]    <= OperandB_Tag_IN;
        r_a_val[i]    <= w_byp_a ? Bcast_Data_IN : OperandA_IN;
        r_b_val[i]    <= w_byp_b ? Bcast_Data_IN : OperandB_IN;
        r_instr[i]    <= Instr_IN;
        r_pc[i]       <= Instr_PC_IN;
        r_wreg[i]     <= WriteRegister_IN;
        r_shamt[i]    <= ShiftAmount_IN;
        r_alu[i]      <= ALU_Control_IN;
        r_regwrite[i] <= RegWrite_IN;
        r_memread[i]  <= MemRead_IN;
        r_memwrite[i] <= MemWrite_IN;
        r_age[i]      <= InstrAge_IN;
      end else begin
        if (w_wake_a[i] && !Flush_IN) r_a_val[i] <= Bcast_Data_IN;
        if (w_wake_b[i] && !Flush_IN) r_b_val[i] <= Bcast_Data_IN;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Count_OUT          <= '0;
      Issue_Valid_OUT    <= 1'b0;
      Instr1_OUT         <= '0;
      Instr1_PC_OUT      <= '0;
      OperandA1_OUT      <= '0;
      OperandB1_OUT      <= '0;
      WriteRegister1_OUT <= '0;
      RegWrite1_OUT      <= 1'b0;
      ALU_Control1_OUT   <= '0;
      MemRead1_OUT       <= 1'b0;
      MemWrite1_OUT      <= 1'b0;
      ShiftAmount1_OUT   <= '0;
      InstrAge_OUT       <= '0;
    end else if (Flush_IN) begin
      Count_OUT       <= '0;
      Issue_Valid_OUT <= 1'b0;
    end else begin
      Count_OUT <= Count_OUT + CNT_W'(w_dispatch) - CNT_W'(w_issue);
      if (!IF_stall_request) begin
        Issue_Valid_OUT <= w_grant_valid;
        if (w_grant_valid) begin
          Instr1_OUT         <= r_instr[w_grant_idx];
          Instr1_PC_OUT      <= r_pc[w_grant_idx];
          OperandA1_OUT      <= r_a_val[w_grant_idx];
          OperandB1_OUT      <= r_b_val[w_grant_idx];
          WriteRegister1_OUT <= r_wreg[w_grant_idx];
          RegWrite1_OUT      <= r_regwrite[w_grant_idx];
          ALU_Control1_OUT   <= r_alu[w_grant_idx];
          MemRead1_OUT       <= r_memread[w_grant_idx];
          MemWrite1_OUT      <= r_memwrite[w_grant_idx];
          ShiftAmount1_OUT   <= r_shamt[w_grant_idx];
          InstrAge_OUT       <= r_age[w_grant_idx];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/issue_queue.md
Name: issue_queue

Overview:
Out-of-order issue queue (reservation station) directly upstream of the EXE stage.
- Accepts renamed instructions from dispatch and holds them until both operands are ready.
- Captures operand values from the result broadcast bus.
- Each cycle, issues the oldest ready entry into EXE's input registers, honouring the EXE stall request.

Parameters:
DEPTH, 8, number of queue entries (power of two, 2..32)
TAG_W, 6, physical-register tag width
AGE_W, 32, instruction age width (matches EXE InstrAge)

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  asynchronous, active-low reset
Dispatch_Valid_IN  in  1  dispatch presents an instruction
Dispatch_Ready_OUT  out  1  queue can accept this cycle
Instr_IN / Instr_PC_IN  in  32/32  instruction and PC
OperandA_IN / OperandB_IN  in  32/32  operand value, meaningful when ready
OperandA_Ready_IN / OperandB_Ready_IN  in  1/1  operand value already known
OperandA_Tag_IN / OperandB_Tag_IN  in  TAG_W/TAG_W  producer tag when not ready
WriteRegister_IN  in  5  destination register
RegWrite_IN, MemRead_IN, MemWrite_IN  in  1 each  control bits
ALU_Control_IN  in  6  ALU control
ShiftAmount_IN  in  5  shift amount
InstrAge_IN  in  AGE_W  program-order age; smaller = older
Bcast_Valid_IN  in  1  result broadcast valid
Bcast_Tag_IN  in  TAG_W  broadcast producer tag
Bcast_Data_IN  in  32  broadcast value
Flush_IN  in  1  squash all queued and issuing instructions
IF_stall_request  in  1  EXE not accepting; hold issue outputs
Issue_Valid_OUT  out  1  issue outputs carry a real instruction
Instr1_OUT, Instr1_PC_OUT, OperandA1_OUT, OperandB1_OUT, WriteRegister1_OUT, RegWrite1_OUT, ALU_Control1_OUT, MemRead1_OUT, MemWrite1_OUT, ShiftAmount1_OUT, InstrAge_OUT  out  (same widths as inputs)  registered issue fields to EXE
Count_OUT  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (RESET=0, async): all entry valid bits, all outputs and Count_OUT go to 0; Dispatch_Ready_OUT=1 once reset is released.
- Dispatch_Ready_OUT = (Count_OUT < DEPTH), from registered count only. A same-cycle issue does not create room: full accepts nothing even if issuing.
- Dispatch: when Dispatch_Valid_IN & Dispatch_Ready_OUT & !Flush_IN, write to the lowest-index free entry.
  - Same-cycle bypass: if an operand is not ready and Bcast_Valid_IN with a matching tag, store Bcast_Data_IN and mark that operand ready.
- Wakeup: each valid entry whose non-ready operand tag equals Bcast_Tag_IN (Bcast_Valid_IN=1) latches Bcast_Data_IN and sets ready. Both operands may wake in the same cycle.
- Select (combinational on registered state): candidate = valid and both operands ready.
  - Pick the smallest InstrAge (unsigned); ties go to the lowest index.
  - Wakeup-to-issue latency is 1 cycle. Dispatch-to-issue latency is ≥1 cycle.
- Issue (posedge, !IF_stall_request, !Flush_IN):
  - With a candidate: load its fields into the *_OUT registers, set Issue_Valid_OUT=1 and free the entry.
  - With no candidate: Issue_Valid_OUT<=0; other outputs hold.
- Stall (IF_stall_request=1): all issue outputs hold and no entry is freed. Dispatch and wakeup continue.
- Flush_IN=1: clear all valid bits, Count_OUT<=0, Issue_Valid_OUT<=0. Flush overrides dispatch, issue and wakeup in that cycle.
- Count_OUT next = Count_OUT + dispatched − issued (both may happen together). It never exceeds DEPTH and never underflows.
- Ages are monotonic and wrap is not supported; the producer of InstrAge guarantees no wrap.
- Broadcast tags with no matching waiting entry are ignored.

Decomposition:
- Shared package: ALU_Control encodings, TAG_W default, AGE_W default.
- One sub-module, oldest_ready_select: a combinational DEPTH-way min-age priority selector. Output: grant index plus valid.

Test Plan:
- Dispatch ADD with both operands ready (A=5, B=7, age 3), no stall → next posedge: Issue_Valid_OUT=1, OperandA1_OUT=5, OperandB1_OUT=7, Count_OUT returns to 0.
- Dispatch entry waiting on tag 12 for A, then Bcast tag 12 data 0x1234 → issues one cycle after the broadcast with OperandA1_OUT=0x1234.
- Three ready entries with ages 9, 4, 6 → issue order 4, 6, 9 on consecutive cycles.
- Fill 8 entries → Dispatch_Ready_OUT=0, further dispatch ignored. Issue one → Dispatch_Ready_OUT=1 the following cycle.
- IF_stall_request=1 for 3 cycles while ready entries exist → outputs unchanged, Count_OUT unchanged. Deassert → issue resumes in age order.
- Flush_IN pulse with 5 entries, and separately RESET asserted mid-wakeup → Count_OUT=0, Issue_Valid_OUT=0, no stale issue afterwards.
